// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM plus an MMIO window (cycle counter, GPIO, debug FIFO).
// Define DMEM_CYCLE_CNT_EN to build the 64-bit cycle counter; otherwise CNT_LO/CNT_HI read 0.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  we,
    output logic [31:0] drdata,
    output logic [31:0] gpio_out,
    output logic        dbg_valid,
    output logic [7:0]  dbg_data,
    input  logic        dbg_ready,
    output logic        bus_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] OffCntLo    = 3'd0;
    localparam logic [2:0] OffCntHi    = 3'd1;
    localparam logic [2:0] OffGpio     = 3'd2;
    localparam logic [2:0] OffFifoData = 3'd3;
    localparam logic [2:0] OffFifoStat = 3'd4;

    // Sub-word offset is irrelevant: accesses always address the aligned word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^daddr[1:0];

    logic          ram_hit, mmio_hit, any_we;
    logic [AW-1:0] widx;
    logic [2:0]    mmio_off;

    assign ram_hit  = (daddr[31:AW+2] == '0);
    assign widx     = daddr[AW+1:2];
    assign mmio_off = daddr[4:2];
    assign mmio_hit = (daddr[31:16] == 16'hFFFF) && (daddr[15:5] == '0) && (mmio_off <= OffFifoStat);
    assign any_we   = |we;

    // RAM: no reset, read-during-write returns the old word.
    logic [31:0] ram_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) ram_q[widx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    logic [63:0] cnt_q;
`ifdef DMEM_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + 64'd1;
    end
`else
    assign cnt_q = '0;
`endif

    logic [31:0] gpio_q;
    logic        gpio_wr;
    assign gpio_wr = mmio_hit && (mmio_off == OffGpio);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q <= '0;
        end else if (gpio_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) gpio_q[8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    assign gpio_out = gpio_q;

    // Debug FIFO
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q, bus_err_q;
    logic          full, empty, pop, push_req, push, drop, ovf_clr, bad_wr;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = !empty && dbg_ready;
    assign push_req = mmio_hit && (mmio_off == OffFifoData) && we[0];
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign ovf_clr  = mmio_hit && (mmio_off == OffFifoStat) && we[1] && dwdata[10];
    assign bad_wr   = any_we && !ram_hit && !mmio_hit;

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= dwdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
            if (bad_wr) bus_err_q <= 1'b1;
        end
    end

    assign dbg_valid = !empty;
    assign dbg_data  = fifo_q[rd_ptr_q];
    assign bus_err   = bus_err_q;

    logic [31:0] fifo_stat;
    assign fifo_stat = {21'b0, overflow_q, full, empty, 8'(count_q)};

    always_comb begin
        drdata = '0;
        if (ram_hit) begin
            drdata = ram_q[widx];
        end else if (mmio_hit) begin
            unique case (mmio_off)
                OffCntLo:    drdata = cnt_q[31:0];
                OffCntHi:    drdata = cnt_q[63:32];
                OffGpio:     drdata = gpio_q;
                OffFifoStat: drdata = fifo_stat;
                default:     drdata = '0;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RISC-V core's data port; the CPU is the initiator (daddr/dwdata/we), this block returns drdata.
- Provides word-organised RAM with byte-lane writes plus a small MMIO window.
- MMIO window holds a 64-bit cycle counter, a GPIO output register and a debug-byte FIFO drained by an external valid/ready sink.
- Sits beside the core in the top level; reads are combinational because the core samples drdata in the same cycle it presents daddr.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words (power of 2)
FIFO_DEPTH, 8, debug FIFO entries (power of 2, 2..128)

Ports:
clk  input  1  clock
reset  input  1  reset: asynchronous, active-high
daddr  input  32  byte address from core
dwdata  input  32  store data, already lane-shifted by core
we  input  4  byte-lane write enables (bit i = byte lane i)
drdata  output  32  read data, combinational from daddr
gpio_out  output  32  GPIO register contents
dbg_valid  output  1  debug FIFO non-empty
dbg_data  output  8  head byte of debug FIFO
dbg_ready  input  1  sink accepts head byte this cycle
bus_err  output  1  sticky: access hit an unmapped address

Behaviour:
- Reset is asynchronous, active-high. It clears cycle counter, gpio_out, FIFO pointers and count, the overflow flag and bus_err. RAM contents are not reset.
- Address map:
  - RAM: 0x0000_0000 .. DEPTH_WORDS*4-1, word index daddr[log2(DEPTH_WORDS)+1:2].
  - MMIO base 0xFFFF_0000:
    - +0x00 CNT_LO (RO)
    - +0x04 CNT_HI (RO)
    - +0x08 GPIO (RW)
    - +0x0C FIFO_DATA (WO, reads 0)
    - +0x10 FIFO_STAT (RW)
- Read path is combinational from daddr; there are no read wait-states. drdata returns the full aligned word; the core does byte/half extraction.
- Writes commit at posedge clk. For each i with we[i]=1, byte lane i of the target word gets dwdata[8i+7:8i]. we=0 means no write.
- RAM read-during-write to the same word returns the old contents in that cycle; new data is visible the next cycle.
- Cycle counter:
  - 64-bit, increments every clk after reset deasserts.
  - Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - Writes to it are ignored.
- GPIO: byte-lane writable, same lane rules as RAM.
- FIFO_DATA:
  - A write with we[0]=1 pushes dwdata[7:0]. Writes with we[0]=0 are ignored.
  - A pop occurs when dbg_valid && dbg_ready at posedge.
  - Push when full is accepted only if a pop occurs the same cycle; otherwise the byte is dropped and overflow is set (sticky).
  - Simultaneous push and pop when empty: the pushed byte is not popped that cycle. dbg_valid rises the next cycle.
  - dbg_data is the head entry, registered storage, stable while dbg_valid && !dbg_ready.
- FIFO_STAT read fields:
  - [7:0] count
  - [8] empty
  - [9] full
  - [10] overflow
  - other bits 0
- Writing FIFO_STAT with we[1]=1 and dwdata[10]=1 clears overflow. If an overflow event occurs in the same cycle, set wins.
- Unmapped address:
  - Read returns 0.
  - Write is ignored and sets bus_err.
  - bus_err is set only when we!=0; unmapped reads do not set it (the core presents arbitrary ALU results on daddr).
  - bus_err clears only on reset.
- All state is updated on posedge clk only; drdata has no registers.

Optional Feature:
- Macro: DMEM_CYCLE_CNT_EN.
- Defined: counter implemented as above.
- Undefined: no counter flops; CNT_LO/CNT_HI read 0 and remain mapped, so they do not raise bus_err on write.

Test Plan:
- Word store 0xDEADBEEF to 0x10 with we=1111, then read 0x10 -> drdata=0xDEADBEEF next cycle; same cycle as the write returns the prior value.
- After the word store, store dwdata=0x00AB0000 with we=0100 to 0x10 -> read 0xDEABBEEF.
- Release reset, wait 5 clk, read 0xFFFF0000 -> 5, within ±0 of the chosen sampling edge; with the macro undefined -> 0.
- Push bytes 0x41..0x48 with dbg_ready=0 -> STAT reads count 8, full 1. Push 0x49 -> dropped, overflow=1. Raise dbg_ready -> sink receives 0x41..0x48 in order, then empty=1, dbg_valid=0.
- Full FIFO, push 0x50 with dbg_ready=1 the same cycle -> accepted, count stays 8, no overflow; 0x50 emerges last.
- Write to 0x8000_0000 with we=1111 -> bus_err=1, no RAM change. Read same address -> drdata=0. Assert reset mid-FIFO-drain -> dbg_valid=0, count 0, gpio_out=0 immediately.
